// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, PC-select encodings, fetch state
// encoding, the reset instruction word and the instruction field layout.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Controller PC-select encodings
  typedef enum logic [1:0] {
    PC_NEXT       = 2'b00,
    PC_JAL_BRANCH = 2'b01,
    PC_JALR       = 2'b10,
    PC_HALT       = 2'b11
  } pcsel_e;

  // Fetch stage states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  // Instruction word field layout (MSB first)
  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] op;
  } instr_fields_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target mux with misalignment check.
// Ports:
//   pcsel         controller PC select (core_pkg::pcsel_e encoding)
//   pc_plus4      sequential successor of the current PC
//   branch_target pc+imm from the datapath
//   jalr_target   ALU result for jalr (bit 0 is cleared here)
//   next_pc       selected target (pc_plus4 when pcsel is halt)
//   misaligned    target is not word aligned (never set on halt)
module pc_next_sel
  import core_pkg::*;
(
  input  logic [1:0]      pcsel,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Target select; halt carries no target, so it is never flagged
  always_comb begin
    next_pc = pc_plus4;
    unique case (pcsel_e'(pcsel))
      PC_NEXT:       next_pc = pc_plus4;
      PC_JAL_BRANCH: next_pc = branch_target;
      PC_JALR:       next_pc = jalr_target & 32'hFFFF_FFFE;
      PC_HALT:       next_pc = pc_plus4;
      default:       next_pc = pc_plus4;
    endcase
    misaligned = (pcsel != PC_HALT) && (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches through a req/ack
// handshake, holds the IR for one execute cycle and applies pcsel.
// Ports:
//   clk, rst                     clock, async active-low reset
//   imem_req/addr/ack/rdata      instruction memory handshake
//   pcsel, branch_target,
//   jalr_target                  next-PC controls, sampled at EXEC close
//   instr, op, func3, func7,
//   rd, rs1, rs2                 IR and its decoded fields
//   pc, pc_plus4                 PC of the IR instruction and successor
//   inst_valid                   high for the single EXEC cycle
//   halted, fault                sticky status
//   instret                      retired instruction count (wraps)
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0]  RESET_PC       = 32'h0000_0000,
  parameter int unsigned  TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic [1:0]        pcsel,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   jalr_target,
  output logic [XLEN-1:0]   instr,
  output logic [6:0]        op,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              inst_valid,
  output logic              halted,
  output logic              fault,
  output logic [XLEN-1:0]   instret
);

  localparam int unsigned TMO_W = 32;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instret_q, instret_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  logic [XLEN-1:0]  pc_plus4_c;
  logic [XLEN-1:0]  next_pc_c;
  logic             misaligned_c;
  instr_fields_t    fields_c;

  assign pc_plus4_c = XLEN'(pc_q + 32'd4);

  pc_next_sel u_pc_next_sel (
    .pcsel         (pcsel),
    .pc_plus4      (pc_plus4_c),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .next_pc       (next_pc_c),
    .misaligned    (misaligned_c)
  );

  // Next-state, datapath register and registered-output decode
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d   = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          tmo_d = TMO_W'(tmo_q + 32'd1);
          if ((TIMEOUT_CYCLES != 0) && (tmo_d == TMO_W'(TIMEOUT_CYCLES))) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_EXEC: begin
        // Counter clears here so the next FETCH starts from zero
        tmo_d = '0;
        if (pcsel == PC_HALT) begin
          instret_d = XLEN'(instret_q + 32'd1);
          state_d   = ST_HALT;
        end else if (misaligned_c) begin
          state_d = ST_FAULT;
        end else begin
          pc_d      = next_pc_c;
          instret_d = XLEN'(instret_q + 32'd1);
          state_d   = ST_FETCH;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // Control outputs are registered images of the next state
    req_d    = (state_d == ST_FETCH);
    valid_d  = (state_d == ST_EXEC);
    halted_d = halted_q | (state_d == ST_HALT);
    fault_d  = fault_q  | (state_d == ST_FAULT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= NOP_INSTR;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign fields_c   = instr_fields_t'(ir_q);

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign instr      = ir_q;
  assign op         = fields_c.op;
  assign func3      = fields_c.func3;
  assign func7      = fields_c.func7;
  assign rd         = fields_c.rd;
  assign rs1        = fields_c.rs1;
  assign rs2        = fields_c.rs2;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_c;
  assign inst_valid = valid_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign instret    = instret_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-cycle RV32I core, directly upstream of the main controller. It owns the PC and fetches from instruction memory through a req/ack handshake. It latches the instruction word and presents decoded fields (op, func3, func7, register indices) to the controller and datapath for one execute cycle. It then applies the controller's `pcsel` decision to compute the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 16, cycles in FETCH without `imem_ack` before FAULT; 0 disables the timeout.

Ports:
- `clk`  input  1  single clock; all state on its rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `imem_req`  output  1  fetch request; held high until `imem_ack`.
- `imem_addr`  output  32  fetch address (= `pc`); stable while `imem_req` is high.
- `imem_ack`  input  1  memory response valid this cycle.
- `imem_rdata`  input  32  instruction word; sampled when `imem_ack` is high.
- `pcsel`  input  2  controller PC select: 00 next, 01 jal/branch, 10 jalr, 11 halt.
- `branch_target`  input  32  pc+imm from the datapath adder.
- `jalr_target`  input  32  ALU result for jalr.
- `instr`  output  32  latched instruction register (IR).
- `op`  output  7  IR[6:0].
- `func3`  output  3  IR[14:12].
- `func7`  output  7  IR[31:25].
- `rd`  output  5  IR[11:7].
- `rs1`  output  5  IR[19:15].
- `rs2`  output  5  IR[24:20].
- `pc`  output  32  PC of the instruction in IR.
- `pc_plus4`  output  32  `pc` + 4, mod 2^32.
- `inst_valid`  output  1  high exactly in EXEC; register-file/memory writes are qualified by it.
- `halted`  output  1  sticky, set on `pcsel`=11.
- `fault`  output  1  sticky, set on a misaligned target or fetch timeout.
- `instret`  output  32  count of retired instructions; wraps.

## Operation
- States: IDLE, FETCH, EXEC, HALT, FAULT.
- IDLE: entered on reset; moves to FETCH on the next clock unconditionally.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. On `imem_ack`, IR <= `imem_rdata` and the state moves to EXEC. Each cycle without ack increments the timeout counter. When `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`, the state moves to FAULT. The counter clears on entry to FETCH.
- EXEC: `inst_valid`=1 for exactly one cycle. At the closing edge, the target is selected:
  - 00: `pc_plus4`
  - 01: `branch_target`
  - 10: {`jalr_target`[31:1],1'b0}
  - 11: no target; the state moves to HALT, `pc` is held, and `instret` increments.
- Target check: if target[1:0]≠00, the state moves to FAULT. `pc` is unchanged and `instret` is not incremented. Otherwise `pc` <= target, `instret` += 1, and the state returns to FETCH.
- HALT and FAULT are absorbing; only reset exits them. `imem_req`=0 and `inst_valid`=0 in both.
- Decoded fields are pure slices of IR and change only when IR loads.
- `imem_ack` is ignored outside FETCH.

## Timing
- Reset (async assert) values:
  - state IDLE
  - `pc`=`RESET_PC`
  - IR=32'h0000_0013 (nop)
  - `instret`=0
  - `imem_req`=0, `inst_valid`=0, `halted`=0, `fault`=0
- Reset deassertion is synchronous to `clk`. The first `imem_req` is asserted in the cycle after the first post-reset edge.
- Control outputs (`imem_req`, `inst_valid`, `halted`, `fault`) decode from registered state only; they have no combinational path from inputs.
- With a zero-wait memory (ack in the same cycle as req), each instruction takes 2 cycles (FETCH, EXEC). Each memory wait cycle adds 1.
- `pcsel`, `branch_target` and `jalr_target` are sampled only at the EXEC closing edge, so the controller's combinational path from `op`/`func3`/`func7` and its zero/negative flags to `pcsel` fits in one cycle.
- Reset asserted mid-FETCH drops `imem_req` immediately. A late ack after that is ignored.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants
  - `pcsel` encodings (`PC_NEXT`, `PC_JAL_BRANCH`, `PC_JALR`, `PC_HALT`), which the controller also uses
  - fetch state encoding
  - `NOP_INSTR`
- One sub-module: `pc_next_sel`, a combinational target mux plus misalignment check. Outputs are `next_pc` and `misaligned`.
- The FSM, IR, PC, timeout counter and `instret` live in `fetch_unit`.

## Test plan
- **Reset and first fetch:** `rst` low then high with `RESET_PC`=0x100 and zero-wait memory. Required: `imem_addr`=0x100 with req high on the 2nd cycle after release; `instret`=0; IR=0x00000013 before the first ack.
- **Sequential run:** 3 instructions with `pcsel`=00 at 2-cycle ack latency. Required: `pc` sequence 0x100, 0x104, 0x108; each EXEC 1 cycle long; `instret`=3.
- **Jal/branch redirect:**
  - `pcsel`=01 with `branch_target`=0x200. Required: next `imem_addr`=0x200.
  - `pcsel`=10 with `jalr_target`=0x301. Required: next `imem_addr`=0x300.
- **Misaligned target:** `pcsel`=01 with `branch_target`=0x202. Required: `fault`=1 next cycle; `pc` stays at the old value; `instret` unchanged; `imem_req` stays 0 forever.
- **Halt and timeout:**
  - `pcsel`=11. Required: `halted`=1; `instret` increments; no further req.
  - Separately, with `TIMEOUT_CYCLES`=4 and no ack. Required: `fault`=1 after 4 FETCH cycles.
- **Reset mid-fetch:** assert `rst` while req is high and waiting, and pulse `imem_ack` during reset. Required: req drops immediately; IR keeps the nop; the refetch after release is from `RESET_PC`.
